rst_sequencer: RTL



---
 rtl/rst_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// Staged reset controller: releases memory, peripheral and core resets in order and serves
// software reset requests. Optional rst_cause output enabled by defining RST_SEQ_CAUSE_EN.
module rst_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_sync,
    input  logic       sw_rst_req,
    output logic       sw_rst_ack,
    output logic       rst_mem,
    output logic       rst_periph,
    output logic       rst_core,
`ifdef RST_SEQ_CAUSE_EN
    output logic       rst_done,
    output logic [1:0] rst_cause
`else
    output logic       rst_done
`endif
);

    typedef enum logic [1:0] {
        HOLD,
        REL_MEM,
        REL_PER,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             armed, armed_nxt;
    logic             sw_accept;

    logic             mem_d, periph_d, core_d, done_d;
`ifdef RST_SEQ_CAUSE_EN
    logic [1:0]       cause_d;
`endif

    // State register; outputs are registered from values decoded off the next state.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state      <= HOLD;
            cnt        <= '0;
            armed      <= 1'b0;
            rst_mem    <= 1'b1;
            rst_periph <= 1'b1;
            rst_core   <= 1'b1;
            rst_done   <= 1'b0;
            sw_rst_ack <= 1'b0;
`ifdef RST_SEQ_CAUSE_EN
            rst_cause  <= 2'b01;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            armed      <= armed_nxt;
            rst_mem    <= mem_d;
            rst_periph <= periph_d;
            rst_core   <= core_d;
            rst_done   <= done_d;
            sw_rst_ack <= sw_accept;
`ifdef RST_SEQ_CAUSE_EN
            rst_cause  <= cause_d;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        sw_accept = 1'b0;
        armed_nxt = armed | ~sw_rst_req;
        case (state)
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = REL_MEM;
                    cnt_nxt   = '0;
                end
            end
            REL_MEM: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = REL_PER;
                    cnt_nxt   = '0;
                end
            end
            REL_PER: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = cnt;
                // A request must have been seen low once before it can restart the sequence.
                if (armed && sw_rst_req) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    sw_accept = 1'b1;
                    armed_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        mem_d    = (state_nxt == HOLD);
        periph_d = (state_nxt == HOLD) || (state_nxt == REL_MEM);
        core_d   = (state_nxt != RUN);
        done_d   = (state_nxt == RUN);
`ifdef RST_SEQ_CAUSE_EN
        cause_d  = sw_accept ? 2'b10 : rst_cause;
`endif
    end

endmodule
